// File: rtl/neural_simd_unblend.sv
// neural_simd_unblend: recovers four 8-bit blend weights from blended lanes.
// Each lane inverts r = (a*m + b*(256-m)) >> 8 with m = floor(n*256 / d).
// A restoring radix-2 divider produces the quotient, one bit per cycle for all four
// lanes at once. The four lanes share a single step counter.
module neural_simd_unblend (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] rd,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mask,
  output logic [3:0]  flag_deg,
  output logic [3:0]  flag_rng,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e           state_q;
  logic [31:0]      a_q, b_q, r_q;
  logic [3:0]       cnt_q;
  logic [3:0][7:0]  rem_q;
  logic [3:0][15:0] quo_q;

  logic [3:0][7:0]  d_c;
  logic [3:0][9:0]  n_c;
  logic [3:0][15:0] dvd_c;
  logic [3:0][8:0]  trial_c;
  logic [3:0][8:0]  diff_c;
  logic [3:0]       take_c;
  logic [3:0][7:0]  rem_nx;
  logic [3:0][15:0] quo_nx;
  logic [3:0][7:0]  mask_c;
  logic [3:0]       deg_c, rng_c;

  // Handshake outputs; both are forced low while reset is asserted.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone) && !rst;

  // Per-lane operand preparation, one divider step, and final weight/flag selection.
  always_comb begin
    d_c     = '0;
    n_c     = '0;
    dvd_c   = '0;
    trial_c = '0;
    diff_c  = '0;
    take_c  = '0;
    rem_nx  = '0;
    quo_nx  = '0;
    mask_c  = '0;
    deg_c   = '0;
    rng_c   = '0;
    for (int i = 0; i < 4; i++) begin
      if (a_q[8*i +: 8] >= b_q[8*i +: 8]) begin
        d_c[i] = a_q[8*i +: 8] - b_q[8*i +: 8];
        n_c[i] = {2'b00, r_q[8*i +: 8]} - {2'b00, b_q[8*i +: 8]};
      end else begin
        d_c[i] = b_q[8*i +: 8] - a_q[8*i +: 8];
        n_c[i] = {2'b00, b_q[8*i +: 8]} - {2'b00, r_q[8*i +: 8]};
      end
      // The divider only yields a meaningful quotient for 0 <= n <= d, so n fits in 8 bits.
      dvd_c[i]   = {n_c[i][7:0], 8'h00};
      trial_c[i] = {rem_q[i], dvd_c[i][4'd15 - cnt_q]};
      diff_c[i]  = trial_c[i] - {1'b0, d_c[i]};
      take_c[i]  = trial_c[i] >= {1'b0, d_c[i]};
      rem_nx[i]  = take_c[i] ? diff_c[i][7:0] : trial_c[i][7:0];
      quo_nx[i]  = {quo_q[i][14:0], take_c[i]};

      deg_c[i] = (d_c[i] == 8'h00);
      if (deg_c[i]) begin
        mask_c[i] = 8'hFF;
      end else if (n_c[i][9]) begin
        mask_c[i] = 8'h00;
        rng_c[i]  = 1'b1;
      end else if (n_c[i][8:0] > {1'b0, d_c[i]}) begin
        mask_c[i] = 8'hFF;
        rng_c[i]  = 1'b1;
      end else begin
        mask_c[i] = (|quo_nx[i][15:8]) ? 8'hFF : quo_nx[i][7:0];
      end
    end
  end

  // Control FSM, operand capture, divider state and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mask     <= '0;
      flag_deg <= '0;
      flag_rng <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= rs1;
            b_q     <= rs2;
            r_q     <= rd;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            state_q <= StDiv;
          end
        end
        StDiv: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            mask     <= mask_c;
            flag_deg <= deg_c;
            flag_rng <= rng_c;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_simd_unblend.sv
// Self-checking bench for neural_simd_unblend with a queue-based scoreboard.
module tb_neural_simd_unblend;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs1, rs2, rd;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mask;
  logic [3:0]  flag_deg, flag_rng;
  logic        out_valid;
  logic        out_ready;

  typedef struct packed {
    logic [31:0] mask;
    logic [3:0]  deg;
    logic [3:0]  rng;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  neural_simd_unblend dut (
    .clk       (clk),
    .rst       (rst),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mask      (mask),
    .flag_deg  (flag_deg),
    .flag_rng  (flag_rng),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference: direct integer arithmetic on the blend inversion.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] r);
    exp_t e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      int av, bv, rv, d, n, q;
      av = int'(a[8*i +: 8]);
      bv = int'(b[8*i +: 8]);
      rv = int'(r[8*i +: 8]);
      d  = (av >= bv) ? av - bv : bv - av;
      n  = (av >= bv) ? rv - bv : bv - rv;
      if (d == 0) begin
        e.mask[8*i +: 8] = 8'hFF;
        e.deg[i] = 1'b1;
      end else if (n < 0) begin
        e.mask[8*i +: 8] = 8'h00;
        e.rng[i] = 1'b1;
      end else if (n > d) begin
        e.mask[8*i +: 8] = 8'hFF;
        e.rng[i] = 1'b1;
      end else begin
        q = (n * 256) / d;
        e.mask[8*i +: 8] = (q > 255) ? 8'hFF : q[7:0];
      end
    end
    return e;
  endfunction

  // Present a request and wait (bounded) for its acceptance edge; pushes the expectation.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input exp_t e, output bit ok);
    rs1 = a;
    rs2 = b;
    rd = r;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
      sb_q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  // Count cycles from acceptance until out_valid; -1 if the bound expires.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rs1 = '0;
    rs2 = '0;
    rd = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    checks++;
    if (mask !== 32'h0 || flag_deg !== 4'h0 || flag_rng !== 4'h0) begin
      errors++;
      $display("FAIL reset_out: mask=%h deg=%h rng=%h want 0", mask, flag_deg, flag_rng);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] r, input logic [31:0] emask,
                               input logic [3:0] edeg, input logic [3:0] erng);
    bit   ok;
    int   lat;
    exp_t e;
    out_ready = 1'b0;
    accept(a, b, r, {emask, edeg, erng}, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_accept: in_ready never high", name);
      return;
    end
    wait_out(lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL %s_latency: got %0d want 16", name, lat);
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue empty", name);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (mask !== e.mask) begin
      errors++;
      $display("FAIL %s_mask: got %h want %h", name, mask, e.mask);
    end
    checks++;
    if (flag_deg !== e.deg || flag_rng !== e.rng) begin
      errors++;
      $display("FAIL %s_flags: deg=%h rng=%h want %h %h", name, flag_deg, flag_rng, e.deg, e.rng);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_consume: out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure;
    bit   ok;
    int   lat;
    int   bad;
    exp_t e;
    out_ready = 1'b0;
    accept(32'h64646464, 32'hC8C8C8C8, 32'h9696C864, {32'h808000FF, 4'h0, 4'h0}, ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 16 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL bp_start: ok=%0d lat=%0d want 1 16", ok, lat);
      return;
    end
    e = sb_q.pop_front();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      rs1 = 32'h01020304 + k;
      rs2 = 32'hF0E0D0C0 - k;
      rd = 32'h55AA55AA ^ k;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || mask !== e.mask ||
          flag_deg !== e.deg || flag_rng !== e.rng) begin
        errors++;
        bad++;
        $display("FAIL bp_hold: cyc=%0d out_valid=%b in_ready=%b mask=%h want 1 0 %h",
                 k, out_valid, in_ready, mask, e.mask);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mask !== e.mask) begin
      errors++;
      $display("FAIL bp_consume: out_valid=%b in_ready=%b mask=%h want 0 1 %h",
               out_valid, in_ready, mask, e.mask);
    end
  endtask

  task automatic test_reset_abort;
    bit ok;
    int seen;
    out_ready = 1'b0;
    accept(32'h64646464, 32'hC8C8C8C8, 32'h9696C864, {32'h808000FF, 4'h0, 4'h0}, ok);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_rst: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    if (ok && sb_q.size() > 0) void'(sb_q.pop_back());
    checks++;
    if (mask !== 32'h0 || flag_deg !== 4'h0 || flag_rng !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_clear: mask=%h deg=%h rng=%h in_ready=%b want 0 0 0 1",
               mask, flag_deg, flag_rng, in_ready);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_valid: got %0d out_valid cycles want 0", seen);
    end
    test_directed("after_abort", 32'h64646464, 32'hC8C8C8C8, 32'h9696C864,
                  32'h808000FF, 4'h0, 4'h0);
  endtask

  task automatic test_back_to_back;
    bit          ok;
    int          lat;
    exp_t        e;
    logic [31:0] a, b, r;
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) begin
        int lo, hi;
        a[8*i +: 8] = 8'($urandom_range(255, 0));
        b[8*i +: 8] = (v == 3 && i == 1) ? a[8*i +: 8] : 8'($urandom_range(255, 0));
        lo = (a[8*i +: 8] < b[8*i +: 8]) ? int'(a[8*i +: 8]) : int'(b[8*i +: 8]);
        hi = (a[8*i +: 8] < b[8*i +: 8]) ? int'(b[8*i +: 8]) : int'(a[8*i +: 8]);
        r[8*i +: 8] = (v % 2 == 0) ? 8'($urandom_range(hi, lo)) : 8'($urandom_range(255, 0));
      end
      accept(a, b, r, model(a, b, r), ok);
      wait_out(lat);
      checks++;
      if (!ok || lat != 16 || sb_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_timing: vec=%0d ok=%0d lat=%0d want 1 16", v, ok, lat);
        continue;
      end
      e = sb_q.pop_front();
      checks++;
      if (mask !== e.mask || flag_deg !== e.deg || flag_rng !== e.rng) begin
        errors++;
        $display("FAIL b2b_result: vec=%0d a=%h b=%h r=%h got %h/%h/%h want %h/%h/%h",
                 v, a, b, r, mask, flag_deg, flag_rng, e.mask, e.deg, e.rng);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed("a_lt_b", 32'h64646464, 32'hC8C8C8C8, 32'h9696C864,
                  32'h808000FF, 4'h0, 4'h0);
    test_directed("a_gt_b", 32'hC8C8C8C8, 32'h64646464, 32'h96C86496,
                  32'h80FF0080, 4'h0, 4'h0);
    test_directed("degenerate", 32'h11223344, 32'h11223344, 32'h11223344,
                  32'hFFFFFFFF, 4'hF, 4'h0);
    test_directed("range", 32'h10101010, 32'h20202020, 32'h05301810,
                  32'hFF0080FF, 4'h0, 4'hC);
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
